// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, multi-cycle MDU stalls,
// branch flushes and data-memory freezes, with stall/flush performance counters.
module pipe_hazard_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      inst_id,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_mdu,
  input  logic             branch_taken,
  input  logic             mdu_done,
  input  logic             dmem_stall,
  input  logic             cnt_clr,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             idex_hold,
  output logic             exmem_hold,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             mdu_start,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {RUN, MDU_WAIT} state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic             r_done_pending;
  logic             w_next_pending;
  logic             w_branch_flush;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic [6:0] w_opcode;
  logic [4:0] w_rs1;
  logic [4:0] w_rs2;
  logic       w_use_rs1;
  logic       w_use_rs2;
  logic       w_load_use;

  assign w_opcode = inst_id[6:0];
  assign w_rs1    = inst_id[19:15];
  assign w_rs2    = inst_id[24:20];

  // LUI, AUIPC and JAL carry no rs1; only R-type, stores and branches read rs2.
  assign w_use_rs1 = !((w_opcode == 7'b0110111) || (w_opcode == 7'b0010111) ||
                       (w_opcode == 7'b1101111));
  assign w_use_rs2 = (w_opcode == 7'b0110011) || (w_opcode == 7'b0100011) ||
                     (w_opcode == 7'b1100011);

  assign w_load_use = ex_mem_read && (ex_rd != '0) &&
                      ((w_use_rs1 && (ex_rd == w_rs1)) || (w_use_rs2 && (ex_rd == w_rs2)));

  always_comb begin
    pc_hold        = 1'b0;
    ifid_hold      = 1'b0;
    idex_hold      = 1'b0;
    exmem_hold     = 1'b0;
    ifid_flush     = 1'b0;
    idex_flush     = 1'b0;
    exmem_flush    = 1'b0;
    mdu_start      = 1'b0;
    w_branch_flush = 1'b0;
    w_next_state   = r_state;
    w_next_pending = r_done_pending;
    if (!rst) begin
      unique case (r_state)
        RUN: begin
          if (dmem_stall) begin
            pc_hold    = 1'b1;
            ifid_hold  = 1'b1;
            idex_hold  = 1'b1;
            exmem_hold = 1'b1;
          end else if (ex_mdu) begin
            mdu_start    = 1'b1;
            pc_hold      = 1'b1;
            ifid_hold    = 1'b1;
            idex_hold    = 1'b1;
            exmem_flush  = 1'b1;
            w_next_state = MDU_WAIT;
          end else if (branch_taken) begin
            ifid_flush     = 1'b1;
            idex_flush     = 1'b1;
            w_branch_flush = 1'b1;
          end else if (w_load_use) begin
            pc_hold    = 1'b1;
            ifid_hold  = 1'b1;
            idex_flush = 1'b1;
          end
        end
        MDU_WAIT: begin
          if ((mdu_done || r_done_pending) && !dmem_stall) begin
            w_next_state   = RUN;
            w_next_pending = 1'b0;
          end else if (dmem_stall) begin
            pc_hold    = 1'b1;
            ifid_hold  = 1'b1;
            idex_hold  = 1'b1;
            exmem_hold = 1'b1;
            if (mdu_done) w_next_pending = 1'b1;
          end else begin
            pc_hold     = 1'b1;
            ifid_hold   = 1'b1;
            idex_hold   = 1'b1;
            exmem_flush = 1'b1;
          end
        end
        default: w_next_state = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= RUN;
      r_done_pending <= 1'b0;
    end else begin
      r_state        <= w_next_state;
      r_done_pending <= w_next_pending;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (cnt_clr) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (pc_hold && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_branch_flush && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (4-bit counters so
// saturation is reachable quickly).
module tb_pipe_hazard_ctrl;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   inst_id;
  logic [4:0]    ex_rd;
  logic          ex_mem_read, ex_mdu, branch_taken, mdu_done, dmem_stall, cnt_clr;
  logic          pc_hold, ifid_hold, idex_hold, exmem_hold;
  logic          ifid_flush, idex_flush, exmem_flush, mdu_start;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // {pc_hold, ifid_hold, idex_hold, exmem_hold, ifid_flush, idex_flush, exmem_flush, mdu_start}
  localparam logic [7:0] C_NONE  = 8'b0000_0000;
  localparam logic [7:0] C_LU    = 8'b1100_0100;
  localparam logic [7:0] C_BR    = 8'b0000_1100;
  localparam logic [7:0] C_START = 8'b1110_0011;
  localparam logic [7:0] C_WAIT  = 8'b1110_0010;
  localparam logic [7:0] C_ALL   = 8'b1111_0000;

  localparam logic [31:0] I_ADD = 32'h002081B3; // add x3,x1,x2
  localparam logic [31:0] I_LUI = 32'h000080B7; // lui x1, rs1 field happens to be 1

  pipe_hazard_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .inst_id(inst_id), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_mdu(ex_mdu), .branch_taken(branch_taken),
    .mdu_done(mdu_done), .dmem_stall(dmem_stall), .cnt_clr(cnt_clr),
    .pc_hold(pc_hold), .ifid_hold(ifid_hold), .idex_hold(idex_hold),
    .exmem_hold(exmem_hold), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .mdu_start(mdu_start),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic [7:0] exp);
    #1;
    chk(tag, {24'd0, pc_hold, ifid_hold, idex_hold, exmem_hold,
              ifid_flush, idex_flush, exmem_flush, mdu_start}, {24'd0, exp});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    inst_id = 32'h00000013; ex_rd = '0; ex_mem_read = 0; ex_mdu = 0;
    branch_taken = 0; mdu_done = 0; dmem_stall = 0; cnt_clr = 0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    ex_mdu = 1; branch_taken = 1; dmem_stall = 1;
    inst_id = I_ADD; ex_rd = 5'd1; ex_mem_read = 1;
    chk_ctl("rst_ctl", C_NONE);
    step();
    chk("rst_stall", 32'(stall_cnt), 0);
    chk("rst_flush", 32'(flush_cnt), 0);
    rst = 1'b0;
    idle();
    chk_ctl("idle", C_NONE);

    // load-use on rs1
    inst_id = I_ADD; ex_mem_read = 1; ex_rd = 5'd1;
    chk_ctl("lu_rs1", C_LU);
    step();
    ex_mem_read = 0; ex_rd = 5'd0;
    chk_ctl("lu_bubble_once", C_NONE);
    chk("lu_stall_cnt", 32'(stall_cnt), 1);
    // load-use on rs2
    ex_mem_read = 1; ex_rd = 5'd2;
    chk_ctl("lu_rs2", C_LU);
    step();
    idle(); cnt_clr = 1;
    step();
    cnt_clr = 0;
    chk("clr_stall", 32'(stall_cnt), 0);

    // no hazard: lui has no rs1, x0 never hazards, wrong rd
    inst_id = I_LUI; ex_mem_read = 1; ex_rd = 5'd1;
    chk_ctl("lui_nohaz", C_NONE);
    inst_id = I_ADD; ex_rd = 5'd0;
    chk_ctl("x0_nohaz", C_NONE);
    ex_rd = 5'd3;
    chk_ctl("rd_nohaz", C_NONE);

    // branch wins over load-use
    ex_rd = 5'd1; branch_taken = 1;
    chk_ctl("br_over_lu", C_BR);
    step();
    idle();
    chk("br_flush_cnt", 32'(flush_cnt), 1);
    chk("br_stall_cnt", 32'(stall_cnt), 0);

    // MDU op, done 3 cycles after start
    ex_mdu = 1;
    chk_ctl("mdu_start", C_START);
    step();
    chk_ctl("mdu_wait1", C_WAIT);
    step();
    branch_taken = 1;
    chk_ctl("mdu_wait2_br_ign", C_WAIT);
    step();
    branch_taken = 0; mdu_done = 1;
    chk_ctl("mdu_done", C_NONE);
    step();
    idle();
    chk("mdu_stall_cnt", 32'(stall_cnt), 3);
    mdu_done = 1;
    chk_ctl("run_done_ign", C_NONE);
    mdu_done = 0;

    // mdu_done during dmem_stall is remembered
    ex_mdu = 1;
    chk_ctl("mdu2_start", C_START);
    step();
    ex_mdu = 0; dmem_stall = 1; mdu_done = 1;
    chk_ctl("wait_dmem_done", C_ALL);
    step();
    mdu_done = 0;
    chk_ctl("wait_dmem_pend", C_ALL);
    step();
    dmem_stall = 0;
    chk_ctl("pend_exit", C_NONE);
    step();
    chk_ctl("back_in_run", C_NONE);
    chk("pend_stall_cnt", 32'(stall_cnt), 6);

    // dmem_stall in RUN beats branch; then saturate
    dmem_stall = 1; branch_taken = 1;
    chk_ctl("run_dmem", C_ALL);
    step();
    chk("dmem_stall_cnt", 32'(stall_cnt), 7);
    chk("dmem_no_flush", 32'(flush_cnt), 1);
    for (int i = 0; i < 10; i++) step();
    chk("sat_stall", 32'(stall_cnt), 15);
    step();
    chk("sat_hold", 32'(stall_cnt), 15);
    cnt_clr = 1;
    step();
    cnt_clr = 0;
    chk("clr_prio", 32'(stall_cnt), 0);
    chk("clr_flush", 32'(flush_cnt), 0);

    // reset aborts MDU_WAIT
    idle();
    ex_mdu = 1;
    step();
    chk_ctl("pre_rst_wait", C_WAIT);
    rst = 1'b1;
    chk_ctl("rst_in_wait", C_NONE);
    chk("rst_async_cnt", 32'(stall_cnt), 0);
    step();
    rst = 1'b0;
    ex_mdu = 0;
    chk_ctl("post_rst_run", C_NONE);
    mdu_done = 1;
    chk_ctl("post_rst_done_ign", C_NONE);
    step();
    chk("post_rst_cnt", 32'(stall_cnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter CNT_W, default 16: width of the stall and flush performance counters.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 inst_id  in  32  instruction in ID; rs1=[19:15], rs2=[24:20], opcode=[6:0].
REQ-005 ex_rd  in  5  destination register of the instruction in EX.
REQ-006 ex_mem_read  in  1  EX instruction is a load.
REQ-007 ex_mdu  in  1  EX instruction is a multi-cycle M-extension op.
REQ-008 branch_taken  in  1  EX resolved a taken branch or jump.
REQ-009 mdu_done  in  1  one-cycle pulse: MDU result valid.
REQ-010 dmem_stall  in  1  data memory not ready; whole pipe freezes.
REQ-011 cnt_clr  in  1  synchronous clear of both counters.
REQ-012 pc_hold, ifid_hold, idex_hold, exmem_hold  out  1 each  hold the PC and the named pipeline register.
REQ-013 ifid_flush, idex_flush, exmem_flush  out  1 each  load NOP/zero into the named pipeline register at the next edge.
REQ-014 mdu_start  out  1  one-cycle MDU start pulse.
REQ-015 stall_cnt, flush_cnt  out  CNT_W each  performance counters.

Function
REQ-016 The FSM SHALL have states RUN and MDU_WAIT, plus a done_pending flag.
REQ-017 All outputs are combinational from state, the flag and the inputs, except the counters, which are registered.
REQ-018 Hold and flush of the same register SHALL never be asserted in the same cycle.
REQ-019 use_rs1 = opcode not in {0110111, 0010111, 1101111}; use_rs2 = opcode in {0110011, 0100011, 1100011}.
REQ-020 load_use = ex_mem_read & ex_rd!=0 & ((use_rs1 & ex_rd==rs1) | (use_rs2 & ex_rd==rs2)).
REQ-021 RUN priority 1, dmem_stall: all four holds = 1, no flushes; state unchanged.
REQ-022 RUN priority 2, ex_mdu: mdu_start=1, pc/ifid/idex hold=1, exmem_flush=1; next state MDU_WAIT.
REQ-023 RUN priority 3, branch_taken: ifid_flush=1, idex_flush=1; load_use is ignored that cycle.
REQ-024 RUN priority 4, load_use: pc_hold=1, ifid_hold=1, idex_flush=1; one bubble only.
REQ-025 RUN with no event: all controls 0.
REQ-026 MDU_WAIT, not done: pc/ifid/idex hold=1, exmem_flush=1, mdu_start=0.
REQ-027 MDU_WAIT exit condition: (mdu_done | done_pending) & !dmem_stall; in that cycle all controls = 0, next state RUN, done_pending cleared.
REQ-028 MDU_WAIT with dmem_stall: all four holds = 1 and exmem_flush=0; a mdu_done in that cycle sets done_pending.
REQ-029 mdu_done in RUN SHALL be ignored; branch_taken in MDU_WAIT SHALL be ignored.
REQ-030 stall_cnt SHALL increment on every cycle with pc_hold=1.
REQ-031 flush_cnt SHALL increment on every cycle with branch-caused ifid_flush=1.
REQ-032 Both counters SHALL saturate at all-ones, and cnt_clr SHALL have priority over increment.

Reset
REQ-033 While rst=1: state=RUN, done_pending=0, counters=0.
REQ-034 While rst=1, all hold, flush and mdu_start outputs SHALL be 0 regardless of the other inputs.
REQ-035 Asserting rst during MDU_WAIT SHALL immediately abort to RUN with no further mdu_start.

Verification
REQ-036 inst_id=add x3,x1,x2; ex_mem_read=1; ex_rd=1 -> pc_hold=ifid_hold=idex_flush=1 for exactly one cycle; stall_cnt=1.
REQ-037 Same hazard with inst_id=lui x1 and ex_rd=1 -> no stall; ex_rd=0 -> no stall.
REQ-038 ex_mdu=1, mdu_done arrives 3 cycles after mdu_start:
 - mdu_start is a single pulse;
 - holds stay high 3 cycles, then drop on the mdu_done cycle;
 - stall_cnt=3.
REQ-039 branch_taken=1 and load_use=1 in the same cycle -> only ifid_flush/idex_flush asserted; flush_cnt=1.
REQ-040 MDU_WAIT with mdu_done during dmem_stall -> done_pending=1; on the next cycle with dmem_stall=0, return to RUN without waiting for another mdu_done.
REQ-041 Force stall_cnt to all-ones and keep stalling -> value holds; assert rst mid MDU_WAIT -> RUN, all outputs 0.
